// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one simple memory port between two masters.
// Ports: clk/rst, m0_*/m1_* master ports, s_* memory port, grant, timeout_err.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                s_we_q, s_we_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic                last_q, last_d;
    logic [7:0]          cnt_q, cnt_d;

    logic                busy;
    logic                win_m1;
    logic                expire;
    logic                done;
    logic [DATA_W-1:0]   rsp;

    assign busy   = (state_q == BUSY);
    // On a tie, grant whoever was not served last (last_q=1 means m1).
    assign win_m1 = (m0_req && m1_req) ? ~last_q : m1_req;
    // A same-cycle s_ready beats the watchdog.
    assign expire = busy && !s_ready && (cnt_q == CNT_LAST);
    assign done   = busy && (s_ready || expire);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            last_q    <= 1'b1;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d   = BUSY;
                    grant_d   = win_m1 ? 2'b10 : 2'b01;
                    s_we_d    = win_m1 ? m1_we : m0_we;
                    s_addr_d  = win_m1 ? m1_addr : m0_addr;
                    s_wdata_d = win_m1 ? m1_wdata : m0_wdata;
                    last_d    = win_m1;
                    cnt_d     = 8'd0;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        s_req       = busy;
        s_we        = s_we_q;
        s_addr      = s_addr_q;
        s_wdata     = s_wdata_q;
        grant       = grant_q;
        timeout_err = expire;
        // An aborted transaction returns all ones to its owner.
        rsp         = expire ? '1 : s_rdata;
        m0_ready    = grant_q[0] && done;
        m1_ready    = grant_q[1] && done;
        m0_rdata    = grant_q[0] ? rsp : '0;
        m1_rdata    = grant_q[1] ? rsp : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter.
// Ports: none; drives the arbiter and compares against hand-computed rows.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        s_req, s_we, s_ready;
    logic [7:0]  s_addr;
    logic [15:0] s_wdata, s_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_arbiter #(
        .ADDR_W (8),
        .DATA_W (16),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m0_ready   (m0_ready),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .m1_ready   (m1_ready),
        .s_req      (s_req),
        .s_we       (s_we),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_ready    (s_ready),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        m0_req;
        logic        m0_we;
        logic [7:0]  m0_addr;
        logic [15:0] m0_wdata;
        logic        m1_req;
        logic        m1_we;
        logic [7:0]  m1_addr;
        logic [15:0] m1_wdata;
        logic        s_ready;
        logic [15:0] s_rdata;
        logic [1:0]  e_grant;
        logic        e_sreq;
        logic        chk_s;
        logic        e_swe;
        logic [7:0]  e_saddr;
        logic [15:0] e_swdata;
        logic        e_m0rdy;
        logic [15:0] e_m0rd;
        logic        e_m1rdy;
        logic [15:0] e_m1rd;
        logic        e_to;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic a0r, input logic a0w,
        input logic [7:0] a0a, input logic [15:0] a0d,
        input logic a1r, input logic a1w,
        input logic [7:0] a1a, input logic [15:0] a1d,
        input logic sr, input logic [15:0] srd,
        input logic [1:0] g, input logic sq, input logic cs,
        input logic sw, input logic [7:0] sa, input logic [15:0] sd,
        input logic r0, input logic [15:0] d0,
        input logic r1, input logic [15:0] d1, input logic to);
        vec_t v;
        v.rst = r; v.m0_req = a0r; v.m0_we = a0w;
        v.m0_addr = a0a; v.m0_wdata = a0d;
        v.m1_req = a1r; v.m1_we = a1w;
        v.m1_addr = a1a; v.m1_wdata = a1d;
        v.s_ready = sr; v.s_rdata = srd;
        v.e_grant = g; v.e_sreq = sq; v.chk_s = cs;
        v.e_swe = sw; v.e_saddr = sa; v.e_swdata = sd;
        v.e_m0rdy = r0; v.e_m0rd = d0;
        v.e_m1rdy = r1; v.e_m1rd = d1; v.e_to = to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        m0_req   = v.m0_req;
        m0_we    = v.m0_we;
        m0_addr  = v.m0_addr;
        m0_wdata = v.m0_wdata;
        m1_req   = v.m1_req;
        m1_we    = v.m1_we;
        m1_addr  = v.m1_addr;
        m1_wdata = v.m1_wdata;
        s_ready  = v.s_ready;
        s_rdata  = v.s_rdata;
        #1;
        cyc++;
        chk("grant", 32'(grant), 32'(v.e_grant));
        chk("s_req", 32'(s_req), 32'(v.e_sreq));
        chk("m0_ready", 32'(m0_ready), 32'(v.e_m0rdy));
        chk("m0_rdata", 32'(m0_rdata), 32'(v.e_m0rd));
        chk("m1_ready", 32'(m1_ready), 32'(v.e_m1rdy));
        chk("m1_rdata", 32'(m1_rdata), 32'(v.e_m1rd));
        chk("timeout_err", 32'(timeout_err), 32'(v.e_to));
        if (v.chk_s) begin
            chk("s_we", 32'(s_we), 32'(v.e_swe));
            chk("s_addr", 32'(s_addr), 32'(v.e_saddr));
            chk("s_wdata", 32'(s_wdata), 32'(v.e_swdata));
        end
    endtask

    vec_t tbl[$];
    vec_t zero;
    int   pulses;

    initial begin
        zero = mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000,
                  2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0);

        // reset state
        tbl.push_back(mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b00,0,1,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        // m0 read 0x10, ready in 3rd busy cycle
        tbl.push_back(mk(0, 1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 0,16'h1111, 2'b01,1,1,0,8'h10,16'h0000, 0,16'h1111,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b01,1,1,0,8'h10,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 1,16'hBEEF, 2'b01,1,1,0,8'h10,16'h0000, 1,16'hBEEF,0,16'h0000,0));
        tbl.push_back(zero);
        // reset, then both masters request with zero-wait memory
        tbl.push_back(mk(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,16'h0055, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,16'h0055, 2'b01,1,1,0,8'h01,16'h0000, 1,16'h0055,0,16'h0000,0));
            tbl.push_back(mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,16'h0055, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
            tbl.push_back(mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,16'h0055, 2'b10,1,1,0,8'h02,16'h0000, 0,16'h0000,1,16'h0055,0));
            if (i == 0)
                tbl.push_back(mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,16'h0055, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        end
        tbl.push_back(zero);
        // m1 write; s_* stay put while m1 changes inputs; m0 pending
        tbl.push_back(mk(0, 0,0,8'h00,16'h0000, 1,1,8'h22,16'h1234, 0,16'h0000, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h05,16'h0000, 1,0,8'h33,16'hAAAA, 0,16'h0000, 2'b10,1,1,1,8'h22,16'h1234, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h05,16'h0000, 1,0,8'h33,16'hAAAA, 1,16'h7777, 2'b10,1,1,1,8'h22,16'h1234, 0,16'h0000,1,16'h7777,0));
        tbl.push_back(mk(0, 1,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 1,16'h0101, 2'b01,1,1,0,8'h05,16'h0000, 1,16'h0101,0,16'h0000,0));
        tbl.push_back(zero);
        // reset during busy abandons m0, pointer returns to m0-first
        tbl.push_back(mk(0, 1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b01,1,1,0,8'h40,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(1, 1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b01,1,1,0,8'h40,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h40,16'h0000, 1,0,8'h41,16'h0000, 0,16'h0000, 2'b00,0,1,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        tbl.push_back(mk(0, 1,0,8'h40,16'h0000, 1,0,8'h41,16'h0000, 1,16'h0F0F, 2'b01,1,1,0,8'h40,16'h0000, 1,16'h0F0F,0,16'h0000,0));
        tbl.push_back(zero);

        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) step(tbl[i]);

        // watchdog: memory never answers m0, then m1 is serviced
        step(mk(0, 1,0,8'h60,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        for (int k = 1; k <= 15; k++) begin
            step(mk(0, 1,0,8'h60,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000,
                    2'b01,1,1,0,8'h60,16'h0000,
                    k == 15, (k == 15) ? 16'hFFFF : 16'h0000,
                    0,16'h0000, k == 15));
        end
        step(mk(0, 0,0,8'h00,16'h0000, 1,0,8'h70,16'h0000, 0,16'h0000, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        step(mk(0, 0,0,8'h00,16'h0000, 1,0,8'h70,16'h0000, 1,16'h1357, 2'b10,1,1,0,8'h70,16'h0000, 0,16'h0000,1,16'h1357,0));
        step(zero);

        // zero-wait back-to-back reads from m0
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(mk(0, 1,0,8'(8'h80 + i),16'h0000, 0,0,8'h00,16'h0000,
                    1,16'(16'h2000 + i),
                    2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
            if (m0_ready) pulses++;
            step(mk(0, 1,0,8'(8'h80 + i),16'h0000, 0,0,8'h00,16'h0000,
                    1,16'(16'h2000 + i),
                    2'b01,1,1,0,8'(8'h80 + i),16'h0000,
                    1,16'(16'h2000 + i),0,16'h0000,0));
            if (m0_ready) pulses++;
        end
        chk("b2b_pulses", 32'(pulses), 32'd4);

        // s_ready on the last watchdog cycle wins: no error
        step(mk(0, 1,0,8'h90,16'h0000, 0,0,8'h00,16'h0000, 0,16'h0000, 2'b00,0,0,0,8'h00,16'h0000, 0,16'h0000,0,16'h0000,0));
        for (int k = 1; k <= 15; k++) begin
            step(mk(0, 1,0,8'h90,16'h0000, 0,0,8'h00,16'h0000,
                    k == 15, (k == 15) ? 16'hCAFE : 16'h0000,
                    2'b01,1,1,0,8'h90,16'h0000,
                    k == 15, (k == 15) ? 16'hCAFE : 16'h0000,
                    0,16'h0000, 0));
        end
        step(zero);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
